// File: rtl/ace_ccu_snoop_issuer.sv
// Per-initiator snoop front end: target mask, select/AC issue, CR/CD return and snoop result.
// Optional counters enabled by defining ACE_CCU_SNOOP_ISSUER_STATS_EN.
module ace_ccu_snoop_issuer #(
    parameter int unsigned NumOup    = 4,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    localparam int unsigned SrcWidth = (NumOup > 1) ? $clog2(NumOup) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [3:0]           req_snoop_i,
    input  logic [2:0]           req_prot_i,
    input  logic [SrcWidth-1:0]  req_src_i,
    output logic [NumOup-1:0]    sel_o,
    output logic                 sel_valid_o,
    input  logic                 sel_ready_i,
    output logic                 ac_valid_o,
    input  logic                 ac_ready_i,
    output logic [AddrWidth-1:0] ac_addr_o,
    output logic [3:0]           ac_snoop_o,
    output logic [2:0]           ac_prot_o,
    input  logic                 cr_valid_i,
    output logic                 cr_ready_o,
    input  logic [4:0]           cr_resp_i,
    input  logic                 cd_valid_i,
    output logic                 cd_ready_o,
    input  logic [DataWidth-1:0] cd_data_i,
    input  logic                 cd_last_i,
    output logic                 data_valid_o,
    input  logic                 data_ready_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 data_last_o,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [5:0]           rsp_o
`ifdef ACE_CCU_SNOOP_ISSUER_STATS_EN
    ,
    output logic [31:0]          stat_snoops_o,
    output logic [31:0]          stat_xfers_o
`endif
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StIssue  = 3'd1;
    localparam logic [2:0] StWaitCr = 3'd2;
    localparam logic [2:0] StFwdCd  = 3'd3;
    localparam logic [2:0] StResp   = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [3:0]           snoop_q, snoop_d;
    logic [2:0]           prot_q, prot_d;
    logic [NumOup-1:0]    mask_q, mask_d, req_mask;
    logic                 sel_done_q, sel_done_d;
    logic                 ac_done_q, ac_done_d;
    logic [5:0]           rsp_q, rsp_d;
    logic                 fwd;

    // An out-of-range source index matches no bit, so every port is snooped.
    always_comb begin
        req_mask = '1;
        for (int unsigned i = 0; i < NumOup; i++) begin
            if (req_src_i == SrcWidth'(i)) req_mask[i] = 1'b0;
        end
    end

    assign fwd          = (state_q == StFwdCd);
    // Gated by reset so nothing is offered while the synchronous reset is held.
    assign req_ready_o  = (state_q == StIdle) && rst_ni;
    assign sel_valid_o  = (state_q == StIssue) && !sel_done_q;
    assign ac_valid_o   = (state_q == StIssue) && !ac_done_q;
    assign cr_ready_o   = (state_q == StWaitCr);
    assign data_valid_o = fwd && cd_valid_i;
    assign cd_ready_o   = fwd && data_ready_i;
    assign data_o       = fwd ? cd_data_i : '0;
    assign data_last_o  = fwd && cd_last_i;
    assign rsp_valid_o  = (state_q == StResp);
    assign sel_o        = mask_q;
    assign ac_addr_o    = addr_q;
    assign ac_snoop_o   = snoop_q;
    assign ac_prot_o    = prot_q;
    assign rsp_o        = rsp_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        snoop_d    = snoop_q;
        prot_d     = prot_q;
        mask_d     = mask_q;
        sel_done_d = sel_done_q;
        ac_done_d  = ac_done_q;
        rsp_d      = rsp_q;
        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    addr_d     = req_addr_i;
                    snoop_d    = req_snoop_i;
                    prot_d     = req_prot_i;
                    mask_d     = req_mask;
                    sel_done_d = 1'b0;
                    ac_done_d  = 1'b0;
                    if (req_mask == '0) begin
                        rsp_d   = 6'b100000;
                        state_d = StResp;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                sel_done_d = sel_done_q || (sel_valid_o && sel_ready_i);
                ac_done_d  = ac_done_q || (ac_valid_o && ac_ready_i);
                if (sel_done_d && ac_done_d) begin
                    sel_done_d = 1'b0;
                    ac_done_d  = 1'b0;
                    state_d    = StWaitCr;
                end
            end
            StWaitCr: begin
                if (cr_valid_i) begin
                    rsp_d   = {1'b0, cr_resp_i};
                    state_d = cr_resp_i[0] ? StFwdCd : StResp;
                end
            end
            StFwdCd: begin
                if (cd_valid_i && data_ready_i && cd_last_i) state_d = StResp;
            end
            StResp: begin
                if (rsp_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            snoop_q    <= '0;
            prot_q     <= '0;
            mask_q     <= '0;
            sel_done_q <= 1'b0;
            ac_done_q  <= 1'b0;
            rsp_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            snoop_q    <= snoop_d;
            prot_q     <= prot_d;
            mask_q     <= mask_d;
            sel_done_q <= sel_done_d;
            ac_done_q  <= ac_done_d;
            rsp_q      <= rsp_d;
        end
    end

`ifdef ACE_CCU_SNOOP_ISSUER_STATS_EN
    logic [31:0] stat_snoops_q, stat_snoops_d;
    logic [31:0] stat_xfers_q, stat_xfers_d;

    always_comb begin
        stat_snoops_d = stat_snoops_q;
        stat_xfers_d  = stat_xfers_q;
        if (rsp_valid_o && rsp_ready_i) begin
            if (!rsp_q[5]) stat_snoops_d = stat_snoops_q + 32'd1;
            if (rsp_q[0])  stat_xfers_d  = stat_xfers_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stat_snoops_q <= '0;
            stat_xfers_q  <= '0;
        end else begin
            stat_snoops_q <= stat_snoops_d;
            stat_xfers_q  <= stat_xfers_d;
        end
    end

    assign stat_snoops_o = stat_snoops_q;
    assign stat_xfers_o  = stat_xfers_q;
`endif

endmodule
